i2s_to_lj_conv: RTL and testbench
=================================

Name: i2s_to_lj_conv

Overview:
- Parametrised successor to the fixed I2S-to-16-bit-LJ converter that feeds the 701ES output stage.
- Oversamples external I2S (bck_i/lrck_i/data_i) on mck. Auto-detects slot width (16/24/32 BCK per channel, i.e. 32fs/48fs/64fs).
- Captures L/R words and regenerates a clean left-justified stream of OUT_BITS per channel from an mck divider.
- Adds lock detection and muting, so Fs changes and BCK loss no longer corrupt the DAC stream.

Parameters:
- OUT_BITS, 16: output word width per channel. Legal range 16..24.
- MCK_PER_OBCK, 8: mck cycles per output bck period. Must be even. For mck = 256fs, use 256/(2*OUT_BITS).
- LOCK_FRAMES, 4: consecutive consistent frames required before lock is asserted.
- BCK_TIMEOUT, 64: mck cycles without a bck_i rising edge before lock is dropped.

Ports:
- mck  in  1  system clock, 256fs, at least 4x bck_i.
- reset_n  in  1  asynchronous, active-low reset.
- bck_i  in  1  external I2S bit clock (asynchronous to mck).
- lrck_i  in  1  external I2S word clock; low = left.
- data_i  in  1  external I2S data, MSB first, one-BCK delay.
- bck_o  out  1  regenerated bit clock to the 701ES path.
- lrck_o  out  1  LJ word clock; high = left.
- data_o  out  1  LJ data, MSB first, no delay.
- locked  out  1  input format stable; output carries audio.
- in_bits  out  6  detected slot width: 16, 24 or 32. 0 = unknown.
- frame_err  out  1  one-mck pulse on a format or timeout error.

Behaviour:
- Reset (async assert, sync release): bck_o=0, lrck_o=0, data_o=0, locked=0, in_bits=0, frame_err=0. All counters and shift/holding registers cleared.
- Input sync: 2-FF synchronisers on all three inputs. Edge detect on the synced bck. Data and lrck are sampled on the mck cycle that detects a bck rising edge.
- Slot counter: 6 bits, counts bck rising edges since the last lrck transition, saturates at 63. On each lrck transition:
  - Count is 16/24/32 and equals the previous count: the slot is consistent.
  - Otherwise: slot error.
  - in_bits is updated with the count when it is legal.
- Capture:
  - The first bit after an lrck transition is skipped (I2S delay bit).
  - The following bits shift into a 32-bit register MSB-first, left-aligned.
  - On the next lrck transition the top OUT_BITS are taken. Narrower inputs are zero-padded in the LSBs; wider inputs are truncated (no dither).
  - lrck rising edge completes the left word; lrck falling edge completes the right word and commits the {L,R} pair to the holding register.
- Lock FSM with states UNLOCK, ACQUIRE, LOCK:
  - UNLOCK -> ACQUIRE on the first legal slot.
  - ACQUIRE: counts consistent frames; reaching LOCK_FRAMES -> LOCK, locked=1.
  - Any slot error or bck timeout (BCK_TIMEOUT mck cycles with no bck edge) in any state -> UNLOCK, locked=0, frame counter cleared, frame_err pulses for 1 cycle.
  - A timeout also clears in_bits to 0.
- Output generator:
  - Divider counts 0..MCK_PER_OBCK-1. bck_o=0 for the first half, 1 for the second half.
  - Bit counter counts 0..2*OUT_BITS-1, advanced at divider wrap.
  - lrck_o=1 for bits 0..OUT_BITS-1 (left), 0 for the rest.
  - data_o changes with bck_o falling, so it is stable at bck_o rising. MSB is on bit 0 of each channel.
  - At bit-counter wrap, the holding register loads into the output shift register.
  - The generator free-runs in all states. bck_o and lrck_o are never gated.
- Mute: while locked=0, the output shift register loads zeros, so data_o=0 for whole frames. Never truncate a frame mid-word.
- Alignment: on the first commit after entering LOCK, the divider and bit counter restart at 0 (one-time realign). After that they free-run. Output rate equals input rate by mck/fs ratio.
- Latency: a committed pair reaches data_o at the start of the next output frame: at most 1 frame + 4 mck.
- Simultaneous events: a slot error on the same cycle as a commit takes priority; the pair is discarded.
- Reset mid-frame: outputs go to reset values immediately. After release, the lock sequence restarts from UNLOCK.

Decomposition:
- Shared package i2s_pkg holds:
  - lock state enum;
  - legal slot-width constants (16, 24, 32);
  - LRCK polarity constants (I2S left = 0, LJ left = 1).
- One natural sub-module: lj_serializer (output divider, bit counter, shift register, mute load). It is reusable for the RasPi 32fs path.
- Input sync, capture and the lock FSM stay in the top.

Test Plan:
- 64fs I2S, 24-bit words L=0x123456, R=0xABCDEF, OUT_BITS=16 -> locked=1 after 4 frames, in_bits=32; LJ output L=0x1234 (lrck_o=1), R=0xABCD (lrck_o=0).
- 32fs I2S, 16-bit L=0x8001, R=0x7FFE -> in_bits=16, exact words on data_o, MSB on first bck_o rising after each lrck_o edge.
- bck_i stops mid-frame while locked -> within 64 mck: locked=0, frame_err 1-cycle pulse, in_bits=0; data_o=0 from the next frame; bck_o/lrck_o keep toggling.
- Switch 64fs to 48fs stream -> frame_err pulse at the first 24-count slot; relock after 4 frames with in_bits=24; no partial words on data_o.
- OUT_BITS=24, MCK_PER_OBCK=4 (even-divisor check; lrck_o period 192 mck), 16-bit input 0xC3A5 -> data_o left word 0xC3A500.
- reset_n asserted mid-frame while locked -> all outputs 0 in the same cycle; after release, locked rises only after 4 fresh consistent frames.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S-to-left-justified converter.
package i2s_pkg;

  typedef enum logic [1:0] {StUnlock, StAcquire, StLock} lock_state_e;

  localparam logic [5:0] SlotBits16 = 6'd16;
  localparam logic [5:0] SlotBits24 = 6'd24;
  localparam logic [5:0] SlotBits32 = 6'd32;

  localparam logic LrckI2sLeft = 1'b0;
  localparam logic LrckLjLeft  = 1'b1;

  function automatic logic is_legal_slot(input logic [5:0] cnt);
    return (cnt == SlotBits16) || (cnt == SlotBits24) || (cnt == SlotBits32);
  endfunction

endpackage

// File: rtl/lj_serializer.sv
// Free-running left-justified serializer: mck divider, bit counter and output shift register.
module lj_serializer
  import i2s_pkg::*;
#(
  parameter int unsigned OUT_BITS     = 16,
  parameter int unsigned MCK_PER_OBCK = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sync,
  input  logic                  i_mute,
  input  logic [2*OUT_BITS-1:0] i_pair,
  output logic                  o_bck,
  output logic                  o_lrck,
  output logic                  o_data
);

  localparam int unsigned DivW = $clog2(MCK_PER_OBCK);
  localparam int unsigned BitW = $clog2(2 * OUT_BITS);

  logic [DivW-1:0]       r_div, w_div_n;
  logic [BitW-1:0]       r_bit, w_bit_n;
  logic [2*OUT_BITS-1:0] r_shift, w_shift_n, w_load;
  logic                  r_bck, r_lrck, r_data;

  // Muting is applied only at a frame load, so a word in flight always completes.
  assign w_load = i_mute ? '0 : i_pair;

  always_comb begin
    w_div_n   = r_div + 1'b1;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    if (i_sync) begin
      w_div_n   = '0;
      w_bit_n   = '0;
      w_shift_n = w_load;
    end else if (r_div == DivW'(MCK_PER_OBCK - 1)) begin
      w_div_n = '0;
      if (r_bit == BitW'(2 * OUT_BITS - 1)) begin
        w_bit_n   = '0;
        w_shift_n = w_load;
      end else begin
        w_bit_n   = r_bit + 1'b1;
        w_shift_n = r_shift << 1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_bck   <= 1'b0;
      r_lrck  <= 1'b0;
      r_data  <= 1'b0;
    end else begin
      r_div   <= w_div_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_bck   <= (w_div_n >= DivW'(MCK_PER_OBCK / 2));
      r_lrck  <= (w_bit_n < BitW'(OUT_BITS)) ? LrckLjLeft : ~LrckLjLeft;
      r_data  <= w_shift_n[2*OUT_BITS-1];
    end
  end

  assign o_bck  = r_bck;
  assign o_lrck = r_lrck;
  assign o_data = r_data;

endmodule

// File: rtl/i2s_to_lj_conv.sv
// I2S receiver with slot-width detection and lock/mute, feeding a regenerated LJ output stream.
module i2s_to_lj_conv
  import i2s_pkg::*;
#(
  parameter int unsigned OUT_BITS     = 16,
  parameter int unsigned MCK_PER_OBCK = 8,
  parameter int unsigned LOCK_FRAMES  = 4,
  parameter int unsigned BCK_TIMEOUT  = 64
) (
  input  logic       mck,
  input  logic       reset_n,
  input  logic       bck_i,
  input  logic       lrck_i,
  input  logic       data_i,
  output logic       bck_o,
  output logic       lrck_o,
  output logic       data_o,
  output logic       locked,
  output logic [5:0] in_bits,
  output logic       frame_err
);

  localparam int unsigned ToW = $clog2(BCK_TIMEOUT + 1);
  localparam int unsigned FcW = $clog2(LOCK_FRAMES + 1);

  logic [1:0]            r_bck_sync, r_lrck_sync, r_data_sync;
  logic                  r_bck_prev, r_lrck_prev;
  logic [5:0]            r_slot_cnt, r_prev_cnt, r_in_bits;
  logic [31:0]           r_shift, w_cap;
  logic [4:0]            w_idx;
  logic [OUT_BITS-1:0]   r_left, w_word;
  logic [2*OUT_BITS-1:0] r_hold;
  logic [ToW-1:0]        r_to_cnt;
  logic [FcW-1:0]        r_frame_cnt;
  lock_state_e           r_state;
  logic                  r_locked, r_frame_err, r_realign, r_sync;
  logic                  w_bck_rise, w_lrck, w_data, w_lr_edge, w_right_done;
  logic                  w_legal, w_consistent, w_slot_err, w_commit, w_timeout;

  assign w_bck_rise   = r_bck_sync[1] & ~r_bck_prev;
  assign w_lrck       = r_lrck_sync[1];
  assign w_data       = r_data_sync[1];
  assign w_lr_edge    = w_bck_rise & (w_lrck != r_lrck_prev);
  assign w_right_done = w_lr_edge & (w_lrck == LrckI2sLeft);
  assign w_legal      = is_legal_slot(r_slot_cnt);
  assign w_consistent = w_legal & (r_slot_cnt == r_prev_cnt);
  assign w_slot_err   = w_lr_edge & ~(w_consistent | ((r_state == StUnlock) & w_legal));
  assign w_commit     = w_right_done & ~w_slot_err;
  assign w_timeout    = ~w_bck_rise & (r_to_cnt == ToW'(BCK_TIMEOUT - 1));

  // The bit seen on an lrck edge is the last bit of the finishing word, not the new one.
  assign w_idx = 5'(6'd32 - r_slot_cnt);
  always_comb begin
    w_cap = r_shift;
    if (r_slot_cnt != 6'd0 && r_slot_cnt <= 6'd32) w_cap[w_idx] = w_data;
  end
  assign w_word = w_cap[31 -: OUT_BITS];

  always_ff @(posedge mck or negedge reset_n) begin
    if (!reset_n) begin
      r_bck_sync  <= '0;
      r_lrck_sync <= '0;
      r_data_sync <= '0;
      r_bck_prev  <= 1'b0;
      r_lrck_prev <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_bck_sync  <= {r_bck_sync[0], bck_i};
      r_lrck_sync <= {r_lrck_sync[0], lrck_i};
      r_data_sync <= {r_data_sync[0], data_i};
      r_bck_prev  <= r_bck_sync[1];
      if (w_bck_rise) r_lrck_prev <= w_lrck;
      if (w_bck_rise) r_to_cnt <= '0;
      else if (r_to_cnt != ToW'(BCK_TIMEOUT)) r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge mck or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_cnt <= '0;
      r_shift    <= '0;
      r_left     <= '0;
      r_hold     <= '0;
    end else if (w_lr_edge) begin
      r_slot_cnt <= 6'd1;
      r_shift    <= '0;
      if (!w_right_done) r_left <= w_word;
      else if (w_commit) r_hold <= {r_left, w_word};
    end else if (w_bck_rise) begin
      if (r_slot_cnt != 6'd63) r_slot_cnt <= r_slot_cnt + 1'b1;
      r_shift <= w_cap;
    end
  end

  always_ff @(posedge mck or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StUnlock;
      r_frame_cnt <= '0;
      r_prev_cnt  <= '0;
      r_in_bits   <= '0;
      r_locked    <= 1'b0;
      r_frame_err <= 1'b0;
      r_realign   <= 1'b0;
      r_sync      <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_sync      <= 1'b0;
      if (w_timeout) begin
        r_state     <= StUnlock;
        r_frame_cnt <= '0;
        r_in_bits   <= '0;
        r_locked    <= 1'b0;
        r_frame_err <= 1'b1;
        r_realign   <= 1'b0;
      end else if (w_lr_edge) begin
        r_prev_cnt <= r_slot_cnt;
        if (w_legal) r_in_bits <= r_slot_cnt;
        if (w_slot_err) begin
          r_state     <= StUnlock;
          r_frame_cnt <= '0;
          r_locked    <= 1'b0;
          r_frame_err <= 1'b1;
          r_realign   <= 1'b0;
        end else begin
          case (r_state)
            StUnlock: begin
              r_state     <= StAcquire;
              r_frame_cnt <= '0;
            end
            StAcquire: begin
              if (w_right_done) begin
                if (r_frame_cnt == FcW'(LOCK_FRAMES - 1)) begin
                  r_state     <= StLock;
                  r_locked    <= 1'b1;
                  r_realign   <= 1'b1;
                  r_frame_cnt <= '0;
                end else begin
                  r_frame_cnt <= r_frame_cnt + 1'b1;
                end
              end
            end
            StLock: begin
              // Realign fires one cycle after the commit so the new pair is already held.
              if (w_right_done && r_realign) begin
                r_sync    <= 1'b1;
                r_realign <= 1'b0;
              end
            end
            default: r_state <= StUnlock;
          endcase
        end
      end
    end
  end

  lj_serializer #(
    .OUT_BITS    (OUT_BITS),
    .MCK_PER_OBCK(MCK_PER_OBCK)
  ) u_ser (
    .i_clk  (mck),
    .i_rst_n(reset_n),
    .i_sync (r_sync),
    .i_mute (~r_locked),
    .i_pair (r_hold),
    .o_bck  (bck_o),
    .o_lrck (lrck_o),
    .o_data (data_o)
  );

  assign locked    = r_locked;
  assign in_bits   = r_in_bits;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_i2s_to_lj_conv.sv
// Directed bench: two converters (16-bit/div 8 and 24-bit/div 4) share one I2S source.
module tb_i2s_to_lj_conv;

  logic mck = 1'b0, reset_n = 1'b0, bck_i = 1'b0, lrck_i = 1'b0, data_i = 1'b0;
  logic a_bck, a_lrck, a_data, a_locked, a_ferr;
  logic b_bck, b_lrck, b_data, b_locked, b_ferr;
  logic [5:0] a_in_bits, b_in_bits;
  logic pend = 1'b0;
  int total = 0, bad = 0;

  always #5 mck = ~mck;

  i2s_to_lj_conv #(.OUT_BITS(16), .MCK_PER_OBCK(8), .LOCK_FRAMES(4), .BCK_TIMEOUT(64)) dut_a (
    .mck(mck), .reset_n(reset_n), .bck_i(bck_i), .lrck_i(lrck_i), .data_i(data_i),
    .bck_o(a_bck), .lrck_o(a_lrck), .data_o(a_data), .locked(a_locked),
    .in_bits(a_in_bits), .frame_err(a_ferr)
  );

  i2s_to_lj_conv #(.OUT_BITS(24), .MCK_PER_OBCK(4), .LOCK_FRAMES(4), .BCK_TIMEOUT(64)) dut_b (
    .mck(mck), .reset_n(reset_n), .bck_i(bck_i), .lrck_i(lrck_i), .data_i(data_i),
    .bck_o(b_bck), .lrck_o(b_lrck), .data_o(b_data), .locked(b_locked),
    .in_bits(b_in_bits), .frame_err(b_ferr)
  );

  // I2S slot: data changes on bck falling, one-bit delay carried in pend.
  task automatic send_slot(input logic lr, input logic [31:0] word, input int n, input int half);
    for (int k = 0; k < n; k++) begin
      bck_i = 1'b0;
      if (k == 0) lrck_i = lr;
      data_i = pend;
      pend = word[31-k];
      #(half);
      bck_i = 1'b1;
      #(half);
    end
  endtask

  task automatic send_frames(input logic [31:0] l, input logic [31:0] r, input int n,
                             input int half, input int frames);
    repeat (frames) begin
      send_slot(1'b0, l, n, half);
      send_slot(1'b1, r, n, half);
    end
  endtask

  // Keep bck transitions 2 ns after an mck rising edge.
  task automatic phase_align();
    @(negedge mck);
    #7;
  endtask

  task automatic capture(input bit wide, output logic [23:0] l, output logic [23:0] r,
                         output bit lr_ok, output bit got);
    int n, cnt;
    bit started;
    logic pb, plr, cb, clr, cd;
    logic [47:0] bits;
    n = wide ? 24 : 16;
    cnt = 0; started = 0; got = 0; lr_ok = 1; bits = '0; plr = 1'b1;
    pb = wide ? b_bck : a_bck;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge mck);
      cb  = wide ? b_bck : a_bck;
      clr = wide ? b_lrck : a_lrck;
      cd  = wide ? b_data : a_data;
      if (cb && !pb) begin
        if (!started && clr && !plr) started = 1;
        if (started) begin
          bits = {bits[46:0], cd};
          if (clr !== (cnt < n)) lr_ok = 0;
          cnt++;
          if (cnt == 2 * n) got = 1;
        end
        plr = clr;
      end
      pb = cb;
    end
    l = wide ? bits[47:24] : {8'h00, bits[31:16]};
    r = wide ? bits[23:0]  : {8'h00, bits[15:0]};
  endtask

  task automatic count_ferr(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(negedge mck);
      if (a_ferr === 1'b1) pulses++;
    end
  endtask

  task automatic check_frame(input bit wide, input logic [23:0] el, input logic [23:0] er,
                             input string name);
    logic [23:0] l, r;
    bit ok, got;
    capture(wide, l, r, ok, got);
    capture(wide, l, r, ok, got);
    total++;
    if (!got) begin bad++; $display("FAIL %s_frame got=timeout exp=frame", name); end
    total++;
    if (l !== el) begin bad++; $display("FAIL %s_left got=%h exp=%h", name, l, el); end
    total++;
    if (r !== er) begin bad++; $display("FAIL %s_right got=%h exp=%h", name, r, er); end
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL %s_lrck_o got=%b exp=1", name, ok); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge mck);
    total++; if (a_bck !== 1'b0) begin bad++; $display("FAIL rst_bck got=%b exp=0", a_bck); end
    total++; if (a_lrck !== 1'b0) begin bad++; $display("FAIL rst_lrck got=%b exp=0", a_lrck); end
    total++; if (a_data !== 1'b0) begin bad++; $display("FAIL rst_data got=%b exp=0", a_data); end
    total++; if (a_locked !== 1'b0) begin bad++; $display("FAIL rst_lock got=%b exp=0", a_locked); end
    total++; if (a_in_bits !== 6'd0) begin bad++; $display("FAIL rst_bits got=%0d exp=0", a_in_bits); end
    total++; if (a_ferr !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%b exp=0", a_ferr); end
    reset_n = 1'b1;
  endtask

  task automatic test_64fs();
    phase_align();
    send_frames(32'h12345600, 32'hABCDEF00, 32, 20, 2);
    total++; if (a_locked !== 1'b0) begin bad++; $display("FAIL 64fs_early got=%b exp=0", a_locked); end
    send_frames(32'h12345600, 32'hABCDEF00, 32, 20, 4);
    total++; if (a_locked !== 1'b1) begin bad++; $display("FAIL 64fs_lock got=%b exp=1", a_locked); end
    total++; if (a_in_bits !== 6'd32) begin bad++; $display("FAIL 64fs_bits got=%0d exp=32", a_in_bits); end
    fork
      send_frames(32'h12345600, 32'hABCDEF00, 32, 20, 4);
      check_frame(1'b0, 24'h001234, 24'h00ABCD, "64fs");
    join
  endtask

  task automatic test_32fs();
    send_frames(32'h80010000, 32'h7FFE0000, 16, 40, 8);
    total++; if (a_locked !== 1'b1) begin bad++; $display("FAIL 32fs_lock got=%b exp=1", a_locked); end
    total++; if (a_in_bits !== 6'd16) begin bad++; $display("FAIL 32fs_bits got=%0d exp=16", a_in_bits); end
    fork
      send_frames(32'h80010000, 32'h7FFE0000, 16, 40, 4);
      check_frame(1'b0, 24'h008001, 24'h007FFE, "32fs");
    join
  endtask

  task automatic test_timeout();
    int pulses, rises;
    logic pb;
    send_slot(1'b0, 32'h80010000, 5, 40);
    count_ferr(100, pulses);
    total++; if (pulses != 1) begin bad++; $display("FAIL to_ferr got=%0d exp=1", pulses); end
    total++; if (a_locked !== 1'b0) begin bad++; $display("FAIL to_lock got=%b exp=0", a_locked); end
    total++; if (a_in_bits !== 6'd0) begin bad++; $display("FAIL to_bits got=%0d exp=0", a_in_bits); end
    rises = 0; pb = a_bck;
    repeat (100) begin
      @(negedge mck);
      if (a_bck && !pb) rises++;
      pb = a_bck;
    end
    total++;
    if (rises < 12 || rises > 13) begin bad++; $display("FAIL to_bck_o got=%0d exp=12..13", rises); end
    check_frame(1'b0, 24'h000000, 24'h000000, "to_mute");
  endtask

  task automatic test_switch_48();
    int pulses;
    phase_align();
    send_frames(32'h12345600, 32'hABCDEF00, 32, 20, 8);
    total++; if (a_locked !== 1'b1) begin bad++; $display("FAIL sw_pre got=%b exp=1", a_locked); end
    fork
      send_frames(32'h2468AC00, 32'h13579B00, 24, 20, 8);
      count_ferr(1500, pulses);
    join
    total++; if (pulses != 1) begin bad++; $display("FAIL sw_ferr got=%0d exp=1", pulses); end
    total++; if (a_locked !== 1'b1) begin bad++; $display("FAIL sw_lock got=%b exp=1", a_locked); end
    total++; if (a_in_bits !== 6'd24) begin bad++; $display("FAIL sw_bits got=%0d exp=24", a_in_bits); end
    fork
      send_frames(32'h2468AC00, 32'h13579B00, 24, 20, 6);
      check_frame(1'b0, 24'h002468, 24'h001357, "sw");
    join
  endtask

  task automatic test_out24();
    int period;
    logic pl;
    bit seen;
    send_frames(32'hC3A50000, 32'h5A3C0000, 16, 40, 8);
    total++; if (b_locked !== 1'b1) begin bad++; $display("FAIL o24_lock got=%b exp=1", b_locked); end
    total++; if (b_in_bits !== 6'd16) begin bad++; $display("FAIL o24_bits got=%0d exp=16", b_in_bits); end
    fork
      send_frames(32'hC3A50000, 32'h5A3C0000, 16, 40, 4);
      begin
        period = -1; seen = 0; pl = b_lrck;
        for (int c = 0; c < 500 && period < 0; c++) begin
          @(negedge mck);
          if (seen) period = (b_lrck && !pl) ? c : -1;
          if (b_lrck && !pl && !seen) begin seen = 1; c = 0; end
          pl = b_lrck;
        end
        total++;
        if (period != 192) begin bad++; $display("FAIL o24_period got=%0d exp=192", period); end
        check_frame(1'b1, 24'hC3A500, 24'h5A3C00, "o24");
      end
    join
  endtask

  task automatic test_reset_mid();
    fork
      send_frames(32'hC3A50000, 32'h5A3C0000, 16, 40, 10);
      begin
        #5453;
        reset_n = 1'b0;
        #1;
        total++; if (a_bck !== 1'b0) begin bad++; $display("FAIL rm_bck got=%b exp=0", a_bck); end
        total++; if (a_lrck !== 1'b0) begin bad++; $display("FAIL rm_lrck got=%b exp=0", a_lrck); end
        total++; if (a_data !== 1'b0) begin bad++; $display("FAIL rm_data got=%b exp=0", a_data); end
        total++; if (a_locked !== 1'b0) begin bad++; $display("FAIL rm_lock got=%b exp=0", a_locked); end
        total++; if (a_in_bits !== 6'd0) begin bad++; $display("FAIL rm_bits got=%0d exp=0", a_in_bits); end
        total++; if (b_locked !== 1'b0) begin bad++; $display("FAIL rm_lock24 got=%b exp=0", b_locked); end
        #50;
        reset_n = 1'b1;
        #5120;
        total++; if (a_locked !== 1'b0) begin bad++; $display("FAIL rm_early got=%b exp=0", a_locked); end
      end
    join
    total++; if (a_locked !== 1'b1) begin bad++; $display("FAIL rm_relock got=%b exp=1", a_locked); end
    total++; if (a_in_bits !== 6'd16) begin bad++; $display("FAIL rm_bits16 got=%0d exp=16", a_in_bits); end
  endtask

  initial begin
    test_reset();
    test_64fs();
    test_32fs();
    test_timeout();
    test_switch_48();
    test_out24();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
